vector_alu_sched: RTL and testbench

VECTOR_ALU_SCHED -- requirements
Module: vector_alu_sched

---
 rtl/vector_alu_sched.sv | 121 ++++++++++++
 tb/tb_vector_alu_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_sched.sv
// vector_alu_sched: issue scheduler for a pipelined vector ALU shared by two requesters.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/op/dst/src1/src2 : per-requester issue request and register fields
//   req_ready             : per-requester grant (combinational)
//   hold                  : blocks all grants; in-flight work keeps draining
//   alu_en/alu_op/alu_sel : ALU enable, opcode and operand-mux select
//   wb_valid/wb_dst/wb_id : writeback strobe, destination and originating requester
//   busy/inflight         : in-flight activity and count
module vector_alu_sched #(
  parameter int unsigned LAT  = 4,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0][4:0] req_op,
  input  logic [1:0][4:0] req_dst,
  input  logic [1:0][4:0] req_src1,
  input  logic [1:0][4:0] req_src2,
  output logic [1:0]      req_ready,
  input  logic            hold,
  output logic            alu_en,
  output logic [4:0]      alu_op,
  output logic            alu_sel,
  output logic            wb_valid,
  output logic [4:0]      wb_dst,
  output logic            wb_id,
  output logic            busy,
  output logic [3:0]      inflight
);

  logic [NREG-1:0] pending;
  logic            ptr;
  logic [4:0]      last_op;
  logic            last_sel;

  logic            pv [LAT];
  logic [4:0]      pd [LAT];
  logic            pi [LAT];

  logic [1:0]      elig;
  logic            issue;
  logic            g;
  logic [4:0]      g_dst;

  function automatic logic is_pend(input logic [NREG-1:0] sb, input logic [4:0] idx);
    return (32'(idx) < NREG) ? sb[idx] : 1'b0;
  endfunction

  always_comb begin
    elig      = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = ~rst & ~hold & req_valid[i]
              & ~is_pend(pending, req_src1[i])
              & ~is_pend(pending, req_src2[i])
              & ~is_pend(pending, req_dst[i]);
    end
    issue = |elig;
    // Pointer decides only when both are eligible; otherwise the single eligible one wins.
    g     = (elig == 2'b11) ? ptr : elig[1];
    g_dst = req_dst[g];
    if (issue) req_ready[g] = 1'b1;
  end

  assign alu_en   = issue;
  assign alu_op   = issue ? req_op[g] : last_op;
  assign alu_sel  = issue ? g : last_sel;

  assign wb_valid = pv[LAT-1];
  assign wb_dst   = pd[LAT-1];
  assign wb_id    = pi[LAT-1];
  assign busy     = (inflight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      last_op  <= '0;
      last_sel <= 1'b0;
      inflight <= '0;
    end else begin
      if (issue) begin
        ptr      <= ~g;
        last_op  <= req_op[g];
        last_sel <= g;
      end
      if (issue && !wb_valid)      inflight <= inflight + 4'd1;
      else if (!issue && wb_valid) inflight <= inflight - 4'd1;
    end
  end

  // Clear precedes set so that a same-cycle set on the same bit wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wb_valid && (32'(wb_dst) < NREG)) pending[wb_dst] <= 1'b0;
      if (issue && (32'(g_dst) < NREG))     pending[g_dst]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        pv[k] <= 1'b0;
        pd[k] <= '0;
        pi[k] <= 1'b0;
      end
    end else begin
      pv[0] <= issue;
      pd[0] <= issue ? g_dst : 5'd0;
      pi[0] <= issue ? g : 1'b0;
      for (int unsigned k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
        pi[k] <= pi[k-1];
      end
    end
  end

endmodule

// File: tb/tb_vector_alu_sched.sv
// tb_vector_alu_sched: directed table-driven bench for vector_alu_sched (LAT=4).
module tb_vector_alu_sched;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0][4:0] req_op, req_dst, req_src1, req_src2;
  logic [1:0]      req_ready;
  logic            hold;
  logic            alu_en, alu_sel, wb_valid, wb_id, busy;
  logic [4:0]      alu_op, wb_dst;
  logic [3:0]      inflight;

  int n_chk = 0;
  int n_err = 0;

  vector_alu_sched #(.LAT(4), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_dst(req_dst),
    .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
    .hold(hold),
    .alu_en(alu_en), .alu_op(alu_op), .alu_sel(alu_sel),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_id(wb_id),
    .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [4:0] op0, d0, a0, b0;
    logic [4:0] op1, d1, a1, b1;
    logic [1:0] rdy;
    logic       en;
    logic [4:0] aop;
    logic       asel;
    logic       wbv;
    logic [4:0] wbd;
    logic       wbi;
    logic [3:0] infl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input int op0, d0, a0, b0,
                     input int op1, d1, a1, b1, input logic [1:0] rdy,
                     input logic en, input int aop, input logic asel,
                     input logic wbv, input int wbd, input logic wbi, input int infl);
    vec_t e;
    e.v = v;
    e.op0 = 5'(op0); e.d0 = 5'(d0); e.a0 = 5'(a0); e.b0 = 5'(b0);
    e.op1 = 5'(op1); e.d1 = 5'(d1); e.a1 = 5'(a1); e.b1 = 5'(b1);
    e.rdy = rdy; e.en = en; e.aop = 5'(aop); e.asel = asel;
    e.wbv = wbv; e.wbd = 5'(wbd); e.wbi = wbi; e.infl = 4'(infl);
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input int op, d, a, b);
    req_valid[i] = v;
    req_op[i]    = 5'(op);
    req_dst[i]   = 5'(d);
    req_src1[i]  = 5'(a);
    req_src2[i]  = 5'(b);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int nwb;

  initial begin
    // cycle-by-cycle: single issue, RAW stall, then round-robin burst
    //   v      r0: op d a b      r1: op d a b     rdy   en aop sel wbv wbd wbi infl
    add(2'b01,  3, 5, 1, 2,       0, 0, 0, 0,      2'b01, 1, 3, 0, 0, 0, 0, 0);
    add(2'b10,  0, 0, 0, 0,       7, 9, 5, 6,      2'b00, 0, 3, 0, 0, 0, 0, 1);
    add(2'b10,  0, 0, 0, 0,       7, 9, 5, 6,      2'b00, 0, 3, 0, 0, 0, 0, 1);
    add(2'b10,  0, 0, 0, 0,       7, 9, 5, 6,      2'b00, 0, 3, 0, 0, 0, 0, 1);
    add(2'b10,  0, 0, 0, 0,       7, 9, 5, 6,      2'b00, 0, 3, 0, 1, 5, 0, 1);
    add(2'b10,  0, 0, 0, 0,       7, 9, 5, 6,      2'b10, 1, 7, 1, 0, 0, 0, 0);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0, 7, 1, 0, 0, 0, 1);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0, 7, 1, 0, 0, 0, 1);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0, 7, 1, 0, 0, 0, 1);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0, 7, 1, 1, 9, 1, 1);
    add(2'b11, 10,10, 1, 2,      20,20, 3, 4,      2'b01, 1,10, 0, 0, 0, 0, 0);
    add(2'b11, 11,11, 1, 2,      20,20, 3, 4,      2'b10, 1,20, 1, 0, 0, 0, 1);
    add(2'b11, 11,11, 1, 2,      21,21, 3, 4,      2'b01, 1,11, 0, 0, 0, 0, 2);
    add(2'b11, 12,12, 1, 2,      21,21, 3, 4,      2'b10, 1,21, 1, 0, 0, 0, 3);
    add(2'b11, 12,12, 1, 2,      22,22, 3, 4,      2'b01, 1,12, 0, 1,10, 0, 4);
    add(2'b10,  0, 0, 0, 0,      22,22, 3, 4,      2'b10, 1,22, 1, 1,20, 1, 4);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0,22, 1, 1,11, 0, 4);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0,22, 1, 1,21, 1, 3);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0,22, 1, 1,12, 0, 2);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0,22, 1, 1,22, 1, 1);
    add(2'b00,  0, 0, 0, 0,       0, 0, 0, 0,      2'b00, 0,22, 1, 0, 0, 0, 0);

    // reset state, with requests presented
    rst  = 1'b1;
    hold = 1'b0;
    set_req(0, 1, 3, 5, 1, 2);
    set_req(1, 1, 7, 9, 3, 4);
    repeat (2) @(posedge clk);
    smp();
    chk("rst ready",    32'(req_ready), 32'd0);
    chk("rst alu_en",   32'(alu_en),    32'd0);
    chk("rst alu_op",   32'(alu_op),    32'd0);
    chk("rst alu_sel",  32'(alu_sel),   32'd0);
    chk("rst wb_valid", 32'(wb_valid),  32'd0);
    chk("rst wb_dst",   32'(wb_dst),    32'd0);
    chk("rst wb_id",    32'(wb_id),     32'd0);
    chk("rst busy",     32'(busy),      32'd0);
    chk("rst inflight", 32'(inflight),  32'd0);

    for (int r = 0; r < tbl.size(); r++) begin
      cyc();
      rst = 1'b0;
      set_req(0, tbl[r].v[0], tbl[r].op0, tbl[r].d0, tbl[r].a0, tbl[r].b0);
      set_req(1, tbl[r].v[1], tbl[r].op1, tbl[r].d1, tbl[r].a1, tbl[r].b1);
      smp();
      chk($sformatf("row%0d ready", r),    32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d alu_en", r),   32'(alu_en),    32'(tbl[r].en));
      chk($sformatf("row%0d alu_op", r),   32'(alu_op),    32'(tbl[r].aop));
      chk($sformatf("row%0d alu_sel", r),  32'(alu_sel),   32'(tbl[r].asel));
      chk($sformatf("row%0d wb_valid", r), 32'(wb_valid),  32'(tbl[r].wbv));
      if (tbl[r].wbv) begin
        chk($sformatf("row%0d wb_dst", r), 32'(wb_dst), 32'(tbl[r].wbd));
        chk($sformatf("row%0d wb_id", r),  32'(wb_id),  32'(tbl[r].wbi));
      end
      chk($sformatf("row%0d inflight", r), 32'(inflight), 32'(tbl[r].infl));
      chk($sformatf("row%0d busy", r),     32'(busy),     32'(tbl[r].infl != 4'd0));
    end

    // hold: three in flight, then hold for six cycles with a request waiting
    for (int k = 0; k < 3; k++) begin
      cyc();
      set_req(0, 1, 1, 13 + k, 1, 2);
      set_req(1, 0, 0, 0, 0, 0);
      smp();
      chk($sformatf("hold issue%0d ready", k), 32'(req_ready), 32'd1);
    end
    nwb = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      hold = 1'b1;
      set_req(0, 0, 0, 0, 0, 0);
      set_req(1, 1, 9, 25, 3, 4);
      smp();
      chk($sformatf("hold%0d ready", k),  32'(req_ready), 32'd0);
      chk($sformatf("hold%0d alu_en", k), 32'(alu_en),    32'd0);
      chk($sformatf("hold%0d alu_op", k), 32'(alu_op),    32'd1);
      if (k == 0) chk("hold inflight start", 32'(inflight), 32'd3);
      if (wb_valid) nwb++;
    end
    chk("hold wb count",   32'(nwb),      32'd3);
    chk("hold busy end",   32'(busy),     32'd0);
    chk("hold inflight end", 32'(inflight), 32'd0);
    cyc();
    hold = 1'b0;
    smp();
    chk("unhold ready",   32'(req_ready), 32'd2);
    chk("unhold alu_en",  32'(alu_en),    32'd1);
    chk("unhold alu_op",  32'(alu_op),    32'd9);
    chk("unhold alu_sel", 32'(alu_sel),   32'd1);
    cyc();
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 2, 16, 1, 2);
    smp();
    chk("second issue ready", 32'(req_ready), 32'd1);
    chk("second issue op",    32'(alu_op),    32'd2);

    // reset two cycles after the first of two issues
    cyc();
    rst = 1'b1;
    set_req(0, 1, 2, 17, 1, 2);
    set_req(1, 1, 4, 26, 3, 4);
    smp();
    chk("midrst ready",    32'(req_ready), 32'd0);
    chk("midrst alu_en",   32'(alu_en),    32'd0);
    chk("midrst alu_op",   32'(alu_op),    32'd0);
    chk("midrst alu_sel",  32'(alu_sel),   32'd0);
    chk("midrst wb_valid", 32'(wb_valid),  32'd0);
    chk("midrst wb_dst",   32'(wb_dst),    32'd0);
    chk("midrst wb_id",    32'(wb_id),     32'd0);
    chk("midrst busy",     32'(busy),      32'd0);
    chk("midrst inflight", 32'(inflight),  32'd0);
    cyc();
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 4, 25, 3, 4);
    smp();
    chk("post rst ready25", 32'(req_ready), 32'd2);
    chk("post rst wb0",     32'(wb_valid),  32'd0);
    chk("post rst infl0",   32'(inflight),  32'd0);
    cyc();
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 5, 16, 1, 2);
    smp();
    chk("post rst ready16", 32'(req_ready), 32'd1);
    chk("post rst wb1",     32'(wb_valid),  32'd0);
    chk("post rst infl1",   32'(inflight),  32'd1);
    cyc();
    set_req(0, 0, 0, 0, 0, 0);
    smp();
    chk("post rst wb2",   32'(wb_valid), 32'd0);
    chk("post rst infl2", 32'(inflight), 32'd2);
    cyc();
    smp();
    chk("post rst wb3", 32'(wb_valid), 32'd0);
    cyc();
    smp();
    chk("post rst wbA valid", 32'(wb_valid), 32'd1);
    chk("post rst wbA dst",   32'(wb_dst),   32'd25);
    chk("post rst wbA id",    32'(wb_id),    32'd1);
    cyc();
    smp();
    chk("post rst wbB valid", 32'(wb_valid), 32'd1);
    chk("post rst wbB dst",   32'(wb_dst),   32'd16);
    chk("post rst wbB id",    32'(wb_id),    32'd0);
    chk("post rst wbB infl",  32'(inflight), 32'd1);
    cyc();
    smp();
    chk("post rst idle wb",   32'(wb_valid), 32'd0);
    chk("post rst idle busy", 32'(busy),     32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
